// File: rtl/palette_lut.sv
// -----------------------------------------------------------------------------
// palette_lut
//
// Multi-layer colour palette lookup for pipe stage 6. Each of NUMBER_OF_LAYERS
// layers owns a palette of PALETTE_SIZE entries, COLOR_WIDTH bits each. The
// block sits between the stage-5 index fetch and the compositor.
//
// Three agents share the palette storage:
//   * a pipeline read port: one lookup per cycle, 1-cycle latency, never
//     stalled;
//   * a controller port: single-entry write, single-entry read (1-cycle
//     latency), and a per-layer clear request;
//   * a clear engine: zeroes the whole array after reset (CLR_ALL) or one
//     layer on request (CLR_LAYER), one entry per cycle.
//
// While the clear engine runs, ctrl_busy is high. In that window every
// controller command is dropped, and pipeline lookups return colour 0 with
// pixel_valid low.
//
// A controller write and a read of the same entry in the same cycle (from
// either port) return the new data (write-first bypass).
//
// Entries whose layer or index is outside the configured range are never
// written, read back as 0, and never produce pixel_valid. This only matters
// when a parameter is not a power of two.
//
// NUMBER_OF_LAYERS and PALETTE_SIZE must each be at least 2.
//
// Ports
//   clk_n             in   1    clock, all logic on its rising edge
//   rst               in   1    synchronous, active-high reset
//   ctrl_write_en     in   1    write ctrl_data_i to [ctrl_layer][ctrl_palette_idx]
//   ctrl_read_en      in   1    read [ctrl_layer][ctrl_palette_idx]
//   ctrl_clear_en     in   1    zero every entry of ctrl_layer
//   ctrl_layer        in   LW   controller layer select
//   ctrl_palette_idx  in   PW   controller entry select
//   ctrl_data_i       in   CW   write data
//   ctrl_data_o       out  CW   read data, valid when ctrl_rd_valid; held otherwise
//   ctrl_rd_valid     out  1    one-cycle pulse, read data ready
//   ctrl_busy         out  1    clear engine active; controller commands dropped
//   pipe_valid_i      in   1    pipeline lookup request
//   pipe_layer        in   LW   pipeline layer
//   pipe_palette_idx  in   PW   pipeline entry
//   pipe_data_o       out  CW   looked-up colour; held when no request
//   pipe_valid_o      out  1    pipe_valid_i delayed one cycle
//   pixel_valid       out  1    lookup accepted, in range and not transparent
// -----------------------------------------------------------------------------
module palette_lut #(
    parameter int NUMBER_OF_LAYERS = 32,
    parameter int PALETTE_SIZE     = 32,
    parameter int COLOR_WIDTH      = 24,
    parameter int TRANSPARENT_IDX  = 0,
    localparam int LAYER_WIDTH     = $clog2(NUMBER_OF_LAYERS),
    localparam int PALETTE_WIDTH   = $clog2(PALETTE_SIZE)
) (
    input  logic                     clk_n,
    input  logic                     rst,

    // Controller port
    input  logic                     ctrl_write_en,
    input  logic                     ctrl_read_en,
    input  logic                     ctrl_clear_en,
    input  logic [LAYER_WIDTH-1:0]   ctrl_layer,
    input  logic [PALETTE_WIDTH-1:0] ctrl_palette_idx,
    input  logic [COLOR_WIDTH-1:0]   ctrl_data_i,
    output logic [COLOR_WIDTH-1:0]   ctrl_data_o,
    output logic                     ctrl_rd_valid,
    output logic                     ctrl_busy,

    // Pipeline port
    input  logic                     pipe_valid_i,
    input  logic [LAYER_WIDTH-1:0]   pipe_layer,
    input  logic [PALETTE_WIDTH-1:0] pipe_palette_idx,
    output logic [COLOR_WIDTH-1:0]   pipe_data_o,
    output logic                     pipe_valid_o,
    output logic                     pixel_valid
);

    // -------------------------------------------------------------------------
    // Storage geometry
    // -------------------------------------------------------------------------
    // The palette is held as one flat array, layer-major, so that the
    // full-array clear can simply walk the flat address from 0 to ENTRIES-1.
    localparam int ENTRIES    = NUMBER_OF_LAYERS * PALETTE_SIZE;
    localparam int ADDR_WIDTH = $clog2(ENTRIES);

    typedef logic [ADDR_WIDTH-1:0]    addr_t;
    typedef logic [COLOR_WIDTH-1:0]   color_t;
    typedef logic [LAYER_WIDTH-1:0]   layer_t;
    typedef logic [PALETTE_WIDTH-1:0] pidx_t;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_LAYER
    } state_t;

    localparam addr_t LAST_ENTRY     = addr_t'(ENTRIES - 1);
    localparam addr_t LAST_LAYER_IDX = addr_t'(PALETTE_SIZE - 1);

    function automatic logic layer_in_range(input layer_t l);
        return int'(l) < NUMBER_OF_LAYERS;
    endfunction

    function automatic logic idx_in_range(input pidx_t i);
        return int'(i) < PALETTE_SIZE;
    endfunction

    function automatic addr_t layer_base(input layer_t l);
        return addr_t'(l) * addr_t'(PALETTE_SIZE);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    color_t mem [ENTRIES];

    state_t state;
    addr_t  clr_cnt;      // flat address in CLR_ALL, entry index in CLR_LAYER
    layer_t clr_layer;    // layer latched when a per-layer clear is accepted

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic   ctrl_addr_ok;
    logic   pipe_addr_ok;
    addr_t  ctrl_addr;
    addr_t  pipe_addr;
    logic   ctrl_wr_fire;
    logic   ctrl_rd_accept;
    logic   pipe_transparent;

    assign ctrl_addr_ok = layer_in_range(ctrl_layer) && idx_in_range(ctrl_palette_idx);
    assign pipe_addr_ok = layer_in_range(pipe_layer) && idx_in_range(pipe_palette_idx);
    assign ctrl_addr    = layer_base(ctrl_layer) + addr_t'(ctrl_palette_idx);
    assign pipe_addr    = layer_base(pipe_layer) + addr_t'(pipe_palette_idx);

    // A clear request in the same cycle wins over a write: the write is lost.
    // Reads are independent of clear and still complete.
    assign ctrl_wr_fire   = ctrl_write_en && !ctrl_busy && !ctrl_clear_en && ctrl_addr_ok;
    assign ctrl_rd_accept = ctrl_read_en && !ctrl_busy;

    assign pipe_transparent = int'(pipe_palette_idx) == TRANSPARENT_IDX;

    // -------------------------------------------------------------------------
    // Clear engine / controller FSM
    // -------------------------------------------------------------------------
    // ctrl_busy is a registered copy of "state != IDLE". It rises the cycle
    // after a clear is accepted and falls the cycle after the last entry of a
    // clear has been written.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation races and mismatch synthesis.
    always_ff @(posedge clk_n) begin
        if (rst) begin
            state     <= CLR_ALL;
            clr_cnt   <= '0;
            clr_layer <= '0;
            ctrl_busy <= 1'b1;
        end else begin
            case (state)
                CLR_ALL: begin
                    // Counter stops on the final entry; the FSM exits instead
                    // of wrapping.
                    if (clr_cnt == LAST_ENTRY) begin
                        state     <= IDLE;
                        ctrl_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + addr_t'(1);
                    end
                end

                IDLE: begin
                    if (ctrl_clear_en) begin
                        state     <= CLR_LAYER;
                        clr_layer <= ctrl_layer;
                        clr_cnt   <= '0;
                        ctrl_busy <= 1'b1;
                    end
                end

                CLR_LAYER: begin
                    if (clr_cnt == LAST_LAYER_IDX) begin
                        state     <= IDLE;
                        ctrl_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + addr_t'(1);
                    end
                end

                default: begin
                    state     <= CLR_ALL;
                    clr_cnt   <= '0;
                    ctrl_busy <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Single write port: clear engine while busy, controller otherwise
    // -------------------------------------------------------------------------
    logic   mem_we;
    addr_t  mem_waddr;
    color_t mem_wdata;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ctrl_addr;
        mem_wdata = ctrl_data_i;
        case (state)
            CLR_ALL: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
            end
            CLR_LAYER: begin
                // A clear request naming a non-existent layer runs its cycles
                // but touches nothing.
                mem_we    = layer_in_range(clr_layer);
                mem_waddr = layer_base(clr_layer) + clr_cnt;
                mem_wdata = '0;
            end
            default: begin
                mem_we = ctrl_wr_fire;
            end
        endcase
    end

    // NOTE: the palette array has no reset branch; clearing it is the job of
    // the CLR_ALL sweep, which keeps the array mappable onto RAM resources.
    always_ff @(posedge clk_n) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read data selection, including write-first bypass
    // -------------------------------------------------------------------------
    // The controller read and write share one address, so a same-cycle
    // read+write always hits the bypass.
    color_t ctrl_rd_word;
    color_t pipe_rd_word;

    always_comb begin
        ctrl_rd_word = '0;
        if (ctrl_addr_ok) begin
            ctrl_rd_word = ctrl_wr_fire ? ctrl_data_i : mem[ctrl_addr];
        end
    end

    always_comb begin
        pipe_rd_word = '0;
        if (!ctrl_busy && pipe_addr_ok) begin
            if (ctrl_wr_fire && (pipe_addr == ctrl_addr)) begin
                pipe_rd_word = ctrl_data_i;
            end else begin
                pipe_rd_word = mem[pipe_addr];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered read outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_n) begin
        if (rst) begin
            ctrl_data_o   <= '0;
            ctrl_rd_valid <= 1'b0;
            pipe_data_o   <= '0;
            pipe_valid_o  <= 1'b0;
            pixel_valid   <= 1'b0;
        end else begin
            ctrl_rd_valid <= ctrl_rd_accept;
            if (ctrl_rd_accept) begin
                ctrl_data_o <= ctrl_rd_word;
            end

            pipe_valid_o <= pipe_valid_i;
            pixel_valid  <= pipe_valid_i && !ctrl_busy && pipe_addr_ok && !pipe_transparent;
            if (pipe_valid_i) begin
                pipe_data_o <= pipe_rd_word;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// -----------------------------------------------------------------------------
// tb_palette_lut
//
// Self-checking bench for palette_lut. A plain 2-D array holds the palette
// contents the design should have; every expected output is derived from it.
// Inputs are driven 1 time unit after each rising edge and outputs sampled at
// the same point, i.e. they reflect the edge that just occurred.
// -----------------------------------------------------------------------------
module tb_palette_lut;

    localparam int L  = 32;
    localparam int P  = 32;
    localparam int CW = 24;
    localparam int LW = 5;
    localparam int PW = 5;

    logic          clk_n = 1'b0;
    logic          rst   = 1'b1;
    logic          ctrl_write_en = 1'b0;
    logic          ctrl_read_en  = 1'b0;
    logic          ctrl_clear_en = 1'b0;
    logic [LW-1:0] ctrl_layer       = '0;
    logic [PW-1:0] ctrl_palette_idx = '0;
    logic [CW-1:0] ctrl_data_i      = '0;
    logic [CW-1:0] ctrl_data_o;
    logic          ctrl_rd_valid;
    logic          ctrl_busy;
    logic          pipe_valid_i     = 1'b0;
    logic [LW-1:0] pipe_layer       = '0;
    logic [PW-1:0] pipe_palette_idx = '0;
    logic [CW-1:0] pipe_data_o;
    logic          pipe_valid_o;
    logic          pixel_valid;

    palette_lut #(
        .NUMBER_OF_LAYERS (L),
        .PALETTE_SIZE     (P),
        .COLOR_WIDTH      (CW),
        .TRANSPARENT_IDX  (0)
    ) dut (
        .clk_n            (clk_n),
        .rst              (rst),
        .ctrl_write_en    (ctrl_write_en),
        .ctrl_read_en     (ctrl_read_en),
        .ctrl_clear_en    (ctrl_clear_en),
        .ctrl_layer       (ctrl_layer),
        .ctrl_palette_idx (ctrl_palette_idx),
        .ctrl_data_i      (ctrl_data_i),
        .ctrl_data_o      (ctrl_data_o),
        .ctrl_rd_valid    (ctrl_rd_valid),
        .ctrl_busy        (ctrl_busy),
        .pipe_valid_i     (pipe_valid_i),
        .pipe_layer       (pipe_layer),
        .pipe_palette_idx (pipe_palette_idx),
        .pipe_data_o      (pipe_data_o),
        .pipe_valid_o     (pipe_valid_o),
        .pixel_valid      (pixel_valid)
    );

    always #5 clk_n = ~clk_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference palette contents.
    logic [CW-1:0] model [L][P];

    task automatic tick();
        @(posedge clk_n);
        #1;
    endtask

    task automatic model_clear_all();
        for (int l = 0; l < L; l++)
            for (int i = 0; i < P; i++)
                model[l][i] = '0;
    endtask

    task automatic ctrl_write(input int l, input int i, input logic [CW-1:0] d);
        ctrl_write_en    = 1'b1;
        ctrl_layer       = LW'(l);
        ctrl_palette_idx = PW'(i);
        ctrl_data_i      = d;
        tick();
        ctrl_write_en    = 1'b0;
        model[l][i]      = d;
    endtask

    task automatic ctrl_read(input int l, input int i, output logic v, output logic [CW-1:0] d);
        ctrl_read_en     = 1'b1;
        ctrl_layer       = LW'(l);
        ctrl_palette_idx = PW'(i);
        tick();
        ctrl_read_en     = 1'b0;
        v = ctrl_rd_valid;
        d = ctrl_data_o;
    endtask

    task automatic pipe_read(input int l, input int i, output logic vo, output logic px,
                             output logic [CW-1:0] d);
        pipe_valid_i     = 1'b1;
        pipe_layer       = LW'(l);
        pipe_palette_idx = PW'(i);
        tick();
        pipe_valid_i     = 1'b0;
        vo = pipe_valid_o;
        px = pixel_valid;
        d  = pipe_data_o;
    endtask

    // Counts cycles with ctrl_busy high, starting with the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (ctrl_busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        int n;
        logic v;
        logic [CW-1:0] d;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (ctrl_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %0b expected 1", ctrl_busy);
        end
        n_checks++;
        if ({ctrl_rd_valid, pipe_valid_o, pixel_valid, ctrl_data_o, pipe_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdv=%0b pvo=%0b px=%0b cd=%0h pd=%0h expected all 0",
                     ctrl_rd_valid, pipe_valid_o, pixel_valid, ctrl_data_o, pipe_data_o);
        end
        rst = 1'b0;
        count_busy(n);
        n_checks++;
        if (n != L * P) begin
            n_fail++; $display("FAIL reset_busy_cycles: got %0d expected %0d", n, L * P);
        end
        model_clear_all();
        ctrl_read(31, 31, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== model[31][31]) begin
            n_fail++; $display("FAIL reset_read_31_31: got v=%0b d=%0h expected v=1 d=%0h",
                               v, d, model[31][31]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_write_pipe();
        logic vo, px, v;
        logic [CW-1:0] d, r;
        ctrl_write(3, 5, 24'hABCDEF);
        pipe_read(3, 5, vo, px, d);
        n_checks++;
        if (vo !== 1'b1 || px !== 1'b1 || d !== 24'hABCDEF) begin
            n_fail++; $display("FAIL pipe_3_5: got vo=%0b px=%0b d=%0h expected 1 1 abcdef", vo, px, d);
        end
        pipe_read(3, 0, vo, px, d);
        n_checks++;
        if (vo !== 1'b1 || px !== 1'b0 || d !== model[3][0]) begin
            n_fail++; $display("FAIL pipe_transparent: got vo=%0b px=%0b d=%0h expected 1 0 %0h",
                               vo, px, d, model[3][0]);
        end
        r = CW'($urandom) | 24'h1;
        ctrl_write(31, 31, r);
        pipe_read(31, 31, vo, px, d);
        n_checks++;
        if (vo !== 1'b1 || px !== 1'b1 || d !== r) begin
            n_fail++; $display("FAIL pipe_31_31: got vo=%0b px=%0b d=%0h expected 1 1 %0h", vo, px, d, r);
        end
        ctrl_read(31, 31, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== r) begin
            n_fail++; $display("FAIL ctrl_read_31_31: got v=%0b d=%0h expected 1 %0h", v, d, r);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bypass_back_to_back();
        for (int k = 0; k < 8; k++) ctrl_write(2, k, CW'($urandom));
        // Same-cycle controller write + pipe read + controller read of [2][7].
        ctrl_write_en    = 1'b1;
        ctrl_read_en     = 1'b1;
        ctrl_layer       = 5'd2;
        ctrl_palette_idx = 5'd7;
        ctrl_data_i      = 24'h123456;
        pipe_valid_i     = 1'b1;
        pipe_layer       = 5'd2;
        pipe_palette_idx = 5'd7;
        tick();
        ctrl_write_en = 1'b0;
        ctrl_read_en  = 1'b0;
        pipe_valid_i  = 1'b0;
        model[2][7]   = 24'h123456;
        n_checks++;
        if (pipe_data_o !== 24'h123456 || pixel_valid !== 1'b1) begin
            n_fail++; $display("FAIL bypass_pipe: got d=%0h px=%0b expected 123456 1", pipe_data_o, pixel_valid);
        end
        n_checks++;
        if (ctrl_rd_valid !== 1'b1 || ctrl_data_o !== 24'h123456) begin
            n_fail++; $display("FAIL bypass_ctrl: got v=%0b d=%0h expected 1 123456", ctrl_rd_valid, ctrl_data_o);
        end
        // Stream: one request per cycle, one result per cycle.
        pipe_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pipe_layer       = 5'd2;
            pipe_palette_idx = PW'(k);
            tick();
            n_checks++;
            if (pipe_valid_o !== 1'b1 || pipe_data_o !== model[2][k] || pixel_valid !== (k != 0)) begin
                n_fail++; $display("FAIL stream_%0d: got vo=%0b d=%0h px=%0b expected 1 %0h %0b",
                                   k, pipe_valid_o, pipe_data_o, pixel_valid, model[2][k], k != 0);
            end
        end
        pipe_valid_i = 1'b0;
        tick();
        n_checks++;
        if (pipe_valid_o !== 1'b0 || pixel_valid !== 1'b0 || pipe_data_o !== model[2][7]) begin
            n_fail++; $display("FAIL stream_hold: got vo=%0b px=%0b d=%0h expected 0 0 %0h",
                               pipe_valid_o, pixel_valid, pipe_data_o, model[2][7]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        logic [CW-1:0] exp_pd, exp_cd, wd;
        logic have_pd, have_cd, we, re, pv, exp_px;
        int wl, wi, pl, pi;
        have_pd = 1'b0;
        have_cd = 1'b0;
        exp_pd  = '0;
        exp_cd  = '0;
        for (int c = 0; c < 200; c++) begin
            we = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 2) != 0);
            pv = (c == 0) || ($urandom_range(0, 3) != 0);
            wl = 8 + $urandom_range(0, 3);
            wi = $urandom_range(0, 3);
            wd = CW'($urandom);
            pl = 8 + $urandom_range(0, 3);
            pi = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                pl = wl;
                pi = wi;
            end
            ctrl_write_en    = we;
            ctrl_read_en     = re;
            ctrl_layer       = LW'(wl);
            ctrl_palette_idx = PW'(wi);
            ctrl_data_i      = wd;
            pipe_valid_i     = pv;
            pipe_layer       = LW'(pl);
            pipe_palette_idx = PW'(pi);
            tick();
            exp_px = 1'b0;
            if (pv) begin
                exp_pd  = (we && pl == wl && pi == wi) ? wd : model[pl][pi];
                have_pd = 1'b1;
                exp_px  = (pi != 0);
            end
            if (re) begin
                exp_cd  = we ? wd : model[wl][wi];
                have_cd = 1'b1;
            end
            n_checks++;
            if (pipe_valid_o !== pv || pixel_valid !== exp_px) begin
                n_fail++; $display("FAIL rand_pipe_flags c=%0d: got vo=%0b px=%0b expected %0b %0b",
                                   c, pipe_valid_o, pixel_valid, pv, exp_px);
            end
            if (have_pd) begin
                n_checks++;
                if (pipe_data_o !== exp_pd) begin
                    n_fail++; $display("FAIL rand_pipe_data c=%0d: got %0h expected %0h", c, pipe_data_o, exp_pd);
                end
            end
            n_checks++;
            if (ctrl_rd_valid !== re) begin
                n_fail++; $display("FAIL rand_rd_valid c=%0d: got %0b expected %0b", c, ctrl_rd_valid, re);
            end
            if (have_cd) begin
                n_checks++;
                if (ctrl_data_o !== exp_cd) begin
                    n_fail++; $display("FAIL rand_ctrl_data c=%0d: got %0h expected %0h", c, ctrl_data_o, exp_cd);
                end
            end
            if (we) model[wl][wi] = wd;
        end
        ctrl_write_en = 1'b0;
        ctrl_read_en  = 1'b0;
        pipe_valid_i  = 1'b0;
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_clear_layer();
        int n;
        logic drive, v;
        logic [CW-1:0] d;
        for (int i = 0; i < P; i++) ctrl_write(4, i, CW'($urandom) | 24'h1);
        for (int i = 0; i < P; i++) ctrl_write(5, i, CW'($urandom) | 24'h1);
        ctrl_clear_en = 1'b1;
        ctrl_layer    = 5'd4;
        tick();
        ctrl_clear_en = 1'b0;
        n = 0;
        while (ctrl_busy === 1'b1 && n < 100) begin
            n++;
            drive = (n <= 6);
            ctrl_write_en    = drive;
            ctrl_read_en     = drive;
            ctrl_layer       = 5'd5;
            ctrl_palette_idx = 5'd3;
            ctrl_data_i      = ~model[5][3];
            pipe_valid_i     = drive;
            pipe_layer       = 5'd5;
            pipe_palette_idx = 5'd3;
            tick();
            if (drive) begin
                n_checks++;
                if (ctrl_rd_valid !== 1'b0 || pipe_valid_o !== 1'b1 || pixel_valid !== 1'b0 ||
                    pipe_data_o !== '0) begin
                    n_fail++; $display("FAIL busy_drop_%0d: got rdv=%0b vo=%0b px=%0b d=%0h expected 0 1 0 0",
                                       n, ctrl_rd_valid, pipe_valid_o, pixel_valid, pipe_data_o);
                end
            end
        end
        ctrl_write_en = 1'b0;
        ctrl_read_en  = 1'b0;
        pipe_valid_i  = 1'b0;
        n_checks++;
        if (n != P) begin
            n_fail++; $display("FAIL clear_layer_busy_cycles: got %0d expected %0d", n, P);
        end
        for (int i = 0; i < P; i++) model[4][i] = '0;
        for (int i = 0; i < P; i++) begin
            ctrl_read(4, i, v, d);
            n_checks++;
            if (v !== 1'b1 || d !== model[4][i]) begin
                n_fail++; $display("FAIL cleared_4_%0d: got v=%0b d=%0h expected 1 %0h", i, v, d, model[4][i]);
            end
            ctrl_read(5, i, v, d);
            n_checks++;
            if (v !== 1'b1 || d !== model[5][i]) begin
                n_fail++; $display("FAIL intact_5_%0d: got v=%0b d=%0h expected 1 %0h", i, v, d, model[5][i]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_rst_mid_clear();
        int n;
        logic v;
        logic [CW-1:0] d;
        ctrl_clear_en = 1'b1;
        ctrl_layer    = 5'd5;
        tick();
        ctrl_clear_en = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ctrl_busy !== 1'b1 || ctrl_rd_valid !== 1'b0 || pipe_valid_o !== 1'b0 || ctrl_data_o !== '0) begin
            n_fail++; $display("FAIL midclear_reset: got busy=%0b rdv=%0b vo=%0b cd=%0h expected 1 0 0 0",
                               ctrl_busy, ctrl_rd_valid, pipe_valid_o, ctrl_data_o);
        end
        rst = 1'b0;
        count_busy(n);
        n_checks++;
        if (n != L * P) begin
            n_fail++; $display("FAIL midclear_busy_cycles: got %0d expected %0d", n, L * P);
        end
        model_clear_all();
        ctrl_read(5, 20, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== model[5][20]) begin
            n_fail++; $display("FAIL midclear_5_20: got v=%0b d=%0h expected 1 %0h", v, d, model[5][20]);
        end
        ctrl_read(3, 5, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== model[3][5]) begin
            n_fail++; $display("FAIL midclear_3_5: got v=%0b d=%0h expected 1 %0h", v, d, model[3][5]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_clear_write();
        int n;
        logic v;
        logic [CW-1:0] d;
        logic [CW-1:0] old_val;
        old_val = 24'h5A5A5A;
        ctrl_write(6, 3, old_val);
        // Clear + write + read in the same IDLE cycle: clear wins, write is
        // dropped, read completes with the pre-existing contents.
        ctrl_clear_en    = 1'b1;
        ctrl_write_en    = 1'b1;
        ctrl_read_en     = 1'b1;
        ctrl_layer       = 5'd6;
        ctrl_palette_idx = 5'd3;
        ctrl_data_i      = 24'hC0FFEE;
        tick();
        ctrl_clear_en = 1'b0;
        ctrl_write_en = 1'b0;
        ctrl_read_en  = 1'b0;
        n_checks++;
        if (ctrl_rd_valid !== 1'b1 || ctrl_data_o !== old_val) begin
            n_fail++; $display("FAIL clear_write_read: got v=%0b d=%0h expected 1 %0h",
                               ctrl_rd_valid, ctrl_data_o, old_val);
        end
        count_busy(n);
        n_checks++;
        if (n != P) begin
            n_fail++; $display("FAIL clear_write_busy_cycles: got %0d expected %0d", n, P);
        end
        for (int i = 0; i < P; i++) model[6][i] = '0;
        ctrl_read(6, 3, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== model[6][3]) begin
            n_fail++; $display("FAIL clear_write_6_3: got v=%0b d=%0h expected 1 %0h", v, d, model[6][3]);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_write_pipe();
        test_bypass_back_to_back();
        test_random();
        test_clear_layer();
        test_rst_mid_clear();
        test_clear_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
